// File: rtl/dl_chunked_adder_if.sv
// Request/response bundle for dl_chunked_adder.
//   master : drives req_val/req_a/req_b/req_cin/req_sub and resp_rdy
//   slave  : drives req_rdy and resp_val/resp_sum/resp_cout/resp_ovf
interface dl_chunked_adder_if #(
  parameter int NUM_BITS = 32
);
  logic                req_val;
  logic                req_rdy;
  logic [NUM_BITS-1:0] req_a;
  logic [NUM_BITS-1:0] req_b;
  logic                req_cin;
  logic                req_sub;
  logic                resp_val;
  logic                resp_rdy;
  logic [NUM_BITS-1:0] resp_sum;
  logic                resp_cout;
  logic                resp_ovf;

  modport master (
    output req_val, req_a, req_b, req_cin, req_sub, resp_rdy,
    input  req_rdy, resp_val, resp_sum, resp_cout, resp_ovf
  );

  modport slave (
    input  req_val, req_a, req_b, req_cin, req_sub, resp_rdy,
    output req_rdy, resp_val, resp_sum, resp_cout, resp_ovf
  );
endinterface

// File: rtl/dl_chunked_adder.sv
// Multi-cycle add/subtract unit: NUM_BITS-wide operands are summed one
// CHUNK_BITS slice per cycle with the ripple carry held in a register.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : dl_chunked_adder_if.slave (request valid/ready + operands,
//            response valid/ready + sum/cout/ovf)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | req_rdy high, waiting for req_val
// S_BUSY | one slice added per cycle, NUM_CHUNKS cycles
// S_DONE | resp_val high, result held until resp_rdy
module dl_chunked_adder #(
  parameter int NUM_BITS   = 32,
  parameter int CHUNK_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dl_chunked_adder_if.slave  bus
);

  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_BITS-1:0] r_a;
  logic [NUM_BITS-1:0] r_b;
  logic [NUM_BITS-1:0] r_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic                r_a_msb;
  logic                r_b_msb;
  logic                r_cout;
  logic                r_ovf;

  logic                w_accept;
  logic                w_last;
  logic                w_c;
  logic [CHUNK_BITS-1:0] w_s;
  logic [NUM_BITS-1:0] w_a_shr;
  logic [NUM_BITS-1:0] w_b_shr;
  logic [NUM_BITS-1:0] w_sum_shr;

  assign w_accept = bus.req_val && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(NUM_CHUNKS - 1));

  // The operands are shifted down one slice per cycle so the adder always
  // sees slice 0; the result is shifted in from the top, so after
  // NUM_CHUNKS cycles slice k sits at its natural position.
  assign {w_c, w_s} = {1'b0, r_a[CHUNK_BITS-1:0]}
                    + {1'b0, r_b[CHUNK_BITS-1:0]}
                    + {{CHUNK_BITS{1'b0}}, r_carry};

  generate
    if (NUM_CHUNKS > 1) begin : g_shift
      assign w_a_shr   = {{CHUNK_BITS{1'b0}}, r_a[NUM_BITS-1:CHUNK_BITS]};
      assign w_b_shr   = {{CHUNK_BITS{1'b0}}, r_b[NUM_BITS-1:CHUNK_BITS]};
      assign w_sum_shr = {w_s, r_sum[NUM_BITS-1:CHUNK_BITS]};
    end else begin : g_single
      assign w_a_shr   = '0;
      assign w_b_shr   = '0;
      assign w_sum_shr = w_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (bus.resp_rdy) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract is A + ~B + 1; req_cin is ignored in that mode.
      r_a     <= bus.req_a;
      r_b     <= bus.req_sub ? ~bus.req_b : bus.req_b;
      r_carry <= bus.req_sub ? 1'b1 : bus.req_cin;
      r_cnt   <= '0;
      // MSBs are kept aside because the operand registers get shifted away.
      r_a_msb <= bus.req_a[NUM_BITS-1];
      r_b_msb <= bus.req_sub ? ~bus.req_b[NUM_BITS-1] : bus.req_b[NUM_BITS-1];
    end else if (r_state == S_BUSY) begin
      r_a     <= w_a_shr;
      r_b     <= w_b_shr;
      r_sum   <= w_sum_shr;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_c;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_s[CHUNK_BITS-1] != r_a_msb);
      end
    end
  end

  assign bus.req_rdy   = (r_state == S_IDLE);
  assign bus.resp_val  = (r_state == S_DONE);
  assign bus.resp_sum  = r_sum;
  assign bus.resp_cout = r_cout;
  assign bus.resp_ovf  = r_ovf;

endmodule

// File: tb/tb_dl_chunked_adder.sv
module tb_dl_chunked_adder;

  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dl_chunked_adder_if #(.NUM_BITS(NB)) bus   ();
  dl_chunked_adder_if #(.NUM_BITS(NB)) bus1  ();
  dl_chunked_adder_if #(.NUM_BITS(NB)) bus32 ();

  dl_chunked_adder #(.NUM_BITS(NB), .CHUNK_BITS(8))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  dl_chunked_adder #(.NUM_BITS(NB), .CHUNK_BITS(32)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dl_chunked_adder #(.NUM_BITS(NB), .CHUNK_BITS(1))  u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Combinational reference: returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic cin);
    logic [31:0] bp;
    logic [32:0] r;
    logic        ov;
    bp = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bp} + {32'd0, (sub ? 1'b1 : cin)};
    ov = (a[31] == bp[31]) && (r[31] != a[31]);
    return {ov, r};
  endfunction

  // Issue one request on the CHUNK_BITS=8 unit and wait for resp_val.
  // Returns at a negedge while the unit sits in DONE (resp_rdy left low).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, output logic [31:0] s, output logic co,
                       output logic ov, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_rdy) chk("req_rdy_wait", {31'd0, bus.req_rdy}, 32'd1);
    bus.req_a = a; bus.req_b = b; bus.req_sub = sub; bus.req_cin = cin;
    bus.req_val = 1'b1;
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    // Scramble request inputs during BUSY; they must not matter.
    bus.req_a = $urandom; bus.req_b = $urandom;
    bus.req_sub = 1'($urandom); bus.req_cin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.resp_val && lat < 100);
    s = bus.resp_sum; co = bus.resp_cout; ov = bus.resp_ovf;
  endtask

  // Hold off resp_rdy for gap cycles checking the result stays put, then
  // complete the handshake.
  task automatic release_resp(input int gap, input string tag, input logic [31:0] es,
                              input logic eco, input logic eov);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_val"}, {31'd0, bus.resp_val}, 32'd1);
      chk({tag, "_hold_sum"}, bus.resp_sum, es);
      chk({tag, "_hold_flags"}, {30'd0, bus.resp_cout, bus.resp_ovf}, {30'd0, eco, eov});
    end
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_rdy = 1'b0;
  endtask

  // Same request on the CHUNK_BITS=32 and CHUNK_BITS=1 units in parallel.
  task automatic alt_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic cin, input string tag);
    logic [33:0] e;
    int cnt, w, lat1, lat32;
    bit seen1, seen32;
    e = ref_model(a, b, sub, cin);
    cnt = 0; w = 0; lat1 = 0; lat32 = 0; seen1 = 0; seen32 = 0;
    @(negedge clk);
    while (!(bus1.req_rdy && bus32.req_rdy) && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus1.req_a = a; bus1.req_b = b; bus1.req_sub = sub; bus1.req_cin = cin;
    bus32.req_a = a; bus32.req_b = b; bus32.req_sub = sub; bus32.req_cin = cin;
    bus1.req_val = 1'b1; bus32.req_val = 1'b1;
    @(posedge clk);
    #1;
    bus1.req_val = 1'b0; bus32.req_val = 1'b0;
    while (!(seen1 && seen32) && cnt < 80) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (!seen1 && bus1.resp_val) begin
        seen1 = 1; lat1 = cnt;
        chk({tag, "_c32_sum"}, bus1.resp_sum, e[31:0]);
        chk({tag, "_c32_flags"}, {30'd0, bus1.resp_cout, bus1.resp_ovf}, {30'd0, e[32], e[33]});
      end
      if (!seen32 && bus32.resp_val) begin
        seen32 = 1; lat32 = cnt;
        chk({tag, "_c1_sum"}, bus32.resp_sum, e[31:0]);
        chk({tag, "_c1_flags"}, {30'd0, bus32.resp_cout, bus32.resp_ovf}, {30'd0, e[32], e[33]});
      end
    end
    chk({tag, "_c32_lat"}, lat1, 32'd1);
    chk({tag, "_c1_lat"}, lat32, 32'd32);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic        co, ov;
    int          lat;
    logic [33:0] e;
    logic [31:0] ra, rb;
    logic        rsub, rcin;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[8] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[9] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b1, 32'h01000101, 1'b0, 1'b0};

    bus.req_val = 0; bus.req_a = 0; bus.req_b = 0; bus.req_sub = 0; bus.req_cin = 0;
    bus.resp_rdy = 0;
    bus1.req_val = 0; bus1.req_a = 0; bus1.req_b = 0; bus1.req_sub = 0; bus1.req_cin = 0;
    bus1.resp_rdy = 1;
    bus32.req_val = 0; bus32.req_a = 0; bus32.req_b = 0; bus32.req_sub = 0; bus32.req_cin = 0;
    bus32.resp_rdy = 1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
    chk("rst_resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("rst_resp_sum", bus.resp_sum, 32'd0);
    chk("rst_flags", {30'd0, bus.resp_cout, bus.resp_ovf}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, co, ov, lat);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].cout});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_lat", i), lat, 32'd4);
      release_resp(1, $sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Backpressure: result held, no accept while DONE
    do_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, s, co, ov, lat);
    chk("bp_sum", s, 32'h00010000);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_rdy", {31'd0, bus.req_rdy}, 32'd0);
      chk("bp_resp_val", {31'd0, bus.resp_val}, 32'd1);
      chk("bp_hold_sum", bus.resp_sum, 32'h00010000);
      chk("bp_hold_flags", {30'd0, bus.resp_cout, bus.resp_ovf}, 32'd0);
      if (i == 1) begin
        bus.req_a = 32'hAAAAAAAA; bus.req_b = 32'h55555555; bus.req_val = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.req_val = 1'b0;
      @(negedge clk);
    end
    chk("bp_after_val", {31'd0, bus.resp_val}, 32'd1);
    chk("bp_after_sum", bus.resp_sum, 32'h00010000);
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    chk("bp_idle_rdy", {31'd0, bus.req_rdy}, 32'd1);
    chk("bp_idle_val", {31'd0, bus.resp_val}, 32'd0);
    @(negedge clk);
    chk("bp_no_accept", {31'd0, bus.req_rdy}, 32'd1);
    do_op(32'd3, 32'd4, 1'b0, 1'b0, s, co, ov, lat);
    chk("bp_next_sum", s, 32'd7);
    release_resp(0, "bp_next", 32'd7, 1'b0, 1'b0);

    // Asynchronous reset in the 3rd BUSY cycle
    @(negedge clk);
    chk("mr_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
    bus.req_a = 32'h12345678; bus.req_b = 32'h11111111; bus.req_sub = 0; bus.req_cin = 0;
    bus.req_val = 1'b1;
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_resp_val", {31'd0, bus.resp_val}, 32'd0);
    chk("mr_resp_sum", bus.resp_sum, 32'd0);
    chk("mr_req_rdy_rst", {31'd0, bus.req_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_req_rdy_rel", {31'd0, bus.req_rdy}, 32'd1);
    do_op(32'd1, 32'd2, 1'b0, 1'b0, s, co, ov, lat);
    chk("mr_new_sum", s, 32'd3);
    chk("mr_new_lat", lat, 32'd4);
    release_resp(0, "mr_new", 32'd3, 1'b0, 1'b0);

    // Random requests with random response gaps against the reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      if ((i % 8) == 0) ra = 32'h7FFFFFFF;
      if ((i % 8) == 1) rb = 32'h80000000;
      rsub = 1'($urandom); rcin = 1'($urandom);
      e = ref_model(ra, rb, rsub, rcin);
      do_op(ra, rb, rsub, rcin, s, co, ov, lat);
      chk($sformatf("rnd%0d_sum", i), s, e[31:0]);
      chk($sformatf("rnd%0d_flags", i), {30'd0, co, ov}, {30'd0, e[32], e[33]});
      chk($sformatf("rnd%0d_lat", i), lat, 32'd4);
      release_resp($urandom_range(0, 2), $sformatf("rnd%0d", i), e[31:0], e[32], e[33]);
    end

    // CHUNK_BITS=32 (latency 1) and CHUNK_BITS=1 (latency 32)
    alt_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, "alt_ripple");
    alt_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, "alt_subovf");
    alt_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "alt_addovf");
    for (int i = 0; i < 20; i++) begin
      alt_op($urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("alt_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
